conv_out_stage: RTL and testbench
=================================

# conv_out_stage

Downstream stage of the 3x3 convolution accelerator. Monitors each pixel pushed into the convolution engine and discards border results whose window is incomplete. Post-processes each valid 32-bit result (arithmetic shift, activation, 8-bit saturation) and queues it in an output FIFO that the CPU drains over the same 4-bit-address memory-mapped bus.

## Interface
Parameters:
- IMG_WIDTH, 8, pixels per row; must match the convolution engine.
- IMG_HEIGHT, 8, rows per frame.
- FIFO_DEPTH, 64, output FIFO entries; power of two, at least 4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- pix_valid  in  1  one pixel was written into the convolution engine this cycle (its addr-0 write strobe).
- conv_y  in  32  engine result register; holds the result for a pixel one cycle after that pixel's pix_valid.
- addr  in  4  register address.
- en  in  1  bus access enable.
- we  in  1  write enable.
- din  in  32  write data.
- dout  out  32  read data; 0 when no read is returning.

## Operation
Register map:
- Addr 0, read: pop the FIFO. Returns {24'sign/zero-ext, data[7:0]}. A read of an empty FIFO returns 0 and does not pop.
- Addr 1, read: status.
  - [0] empty
  - [1] full
  - [2] overflow, sticky
  - [3] done, sticky
  - [15:8] count
- Addr 2, write: clear. Resets counters, FIFO, flags and state. The shift value is kept.
- Addr 3, write: shift amount = din[4:0], range 0-31.
- Other addresses are ignored.

Position tracking:
- col counts 0..IMG_WIDTH-1 and row counts 0..IMG_HEIGHT-1.
- Both advance on pix_valid. col wraps to 0 and increments row; row wraps to 0 after the last pixel.
- The pixel at (row, col) is valid iff row >= 2 and col >= 2.
- This gives (IMG_HEIGHT-2)*(IMG_WIDTH-2) results per frame: 36 for 8x8.

State machine:
- IDLE → RUN on the first pix_valid.
- RUN → DONE on the pix_valid of (IMG_HEIGHT-1, IMG_WIDTH-1).
- DONE → RUN on the next pix_valid; this starts a new frame at (0,0).
- Clear forces IDLE.
- The done flag sets on entering DONE and is cleared only by clear or reset.

Arithmetic on each valid result:
- Interpret conv_y as signed 32-bit.
- Apply an arithmetic right shift by the shift amount.
- Apply activation, then saturation (see Configuration).
- Store 8 bits.

FIFO behaviour:
- A push while full drops the result and sets overflow.
- A push and a pop in the same cycle, including when full, both succeed with no overflow and no change in count.

## Timing
- Reset values: dout=0, count=0, empty=1, full=0, overflow=0, done=0, shift=0, state IDLE, row=col=0.
- pix_valid sampled at edge t → conv_y captured at edge t+1 → FIFO push at edge t+1 → count visible from edge t+1.
- The post-processing path is combinational between the capture and the FIFO write.
- Bus reads have a 1-cycle latency: address sampled at edge t, dout valid after edge t, held for one cycle, then 0.
- A pop takes effect at edge t.
- Clear in the same cycle as a pending push: clear wins and the push is discarded.
- pix_valid in the same cycle as clear is ignored.
- A pending push whose pix_valid preceded a clear by one cycle is discarded.
- Reset asserted mid-frame returns everything to reset values immediately. No partial result survives.
- Back-to-back pix_valid every cycle is supported: one push per cycle.

## Configuration
- CONV_OUT_RELU_EN defined:
  - Negative results are forced to 0, then saturated to 0..255.
  - Stored unsigned; addr-0 reads are zero-extended.
- Undefined:
  - No activation; results saturate to -128..127.
  - Stored two's complement; addr-0 reads are sign-extended.
- The status layout is identical in both builds.

## Structure
- Shared package conv_pkg:
  - Address constants ADDR_POP=0, ADDR_STATUS=1, ADDR_CLEAR=2, ADDR_SHIFT=3.
  - Status bit positions.
  - State enum {IDLE, RUN, DONE}.
  - Default IMG_WIDTH/IMG_HEIGHT; the convolution engine uses the same values.
- One sub-module: conv_out_fifo.
  - Synchronous FIFO, parameterized DEPTH and width 8.
  - Ports: push/pop, full/empty/count, synchronous clear, plus asynchronous rst.
- Position counters, FSM, post-processing and the bus decode stay in conv_out_stage.

## Test plan
- Frame count: reset; shift=0; push 64 pixels with conv_y = 10 each cycle → count=36 after the last push, done=1, overflow=0; 36 pops return 10, then empty=1.
- Border masking: conv_y equals the pixel index 0..63 delayed one cycle → the FIFO holds 18,19,20,21,22,23,26,…,63 in order; no result with row<2 or col<2.
- Arithmetic:
  - shift=4, conv_y=0x00001234 → 0xFF saturated (RELU build) / 0x7F (non-RELU).
  - conv_y=-300 with shift=1 → 0 (RELU) / 0xFFFFFF80 (non-RELU).
  - conv_y=0x50 with shift=0 → 0x50.
- Overflow: FIFO_DEPTH=4, one frame without pops → count=4, full=1, overflow=1; a pop plus push in the same cycle leaves count=4.
- Clear/reset mid-operation:
  - Clear asserted one cycle after pix_valid → no push, count=0, state IDLE, shift kept.
  - Async rst mid-frame → all status bits at reset values, dout=0.
- Read protocol: read an empty addr 0 → dout=0, count unchanged; a status read returns the value one cycle later and dout=0 the following cycle.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants for the 3x3 convolution accelerator: bus addresses, status layout,
// output-stage state encoding and default image geometry.
package conv_pkg;

    localparam int IMG_WIDTH_DEF  = 8;
    localparam int IMG_HEIGHT_DEF = 8;

    localparam logic [3:0] ADDR_POP    = 4'd0;
    localparam logic [3:0] ADDR_STATUS = 4'd1;
    localparam logic [3:0] ADDR_CLEAR  = 4'd2;
    localparam logic [3:0] ADDR_SHIFT  = 4'd3;

    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_DONE      = 3;
    localparam int ST_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/conv_out_fifo.sv
// Synchronous 8-bit output FIFO; a push and a pop in the same cycle both succeed even when full.
module conv_out_fifo #(
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_ok;
    logic          rd_ok;

    assign rd_ok = pop & ~empty;
    assign wr_ok = push & (~full | rd_ok);
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok && !clr)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv_out_stage.sv
// Convolution output stage: border masking, shift/activation/saturation, output FIFO and bus.
// Build option CONV_OUT_RELU_EN selects ReLU with unsigned 0..255 results; otherwise signed -128..127.
module conv_out_stage
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int FIFO_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_valid,
    input  logic [31:0] conv_y,
    input  logic [3:0]  addr,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout
);
    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    function automatic logic [7:0] saturate(input logic signed [31:0] v);
`ifdef CONV_OUT_RELU_EN
        if (v < 0)
            return 8'h00;
        else if (v > 32'sd255)
            return 8'hFF;
        else
            return v[7:0];
`else
        if (v < -32'sd128)
            return 8'h80;
        else if (v > 32'sd127)
            return 8'h7F;
        else
            return v[7:0];
`endif
    endfunction

    function automatic logic [31:0] extend(input logic [7:0] b);
`ifdef CONV_OUT_RELU_EN
        return {24'd0, b};
`else
        return {{24{b[7]}}, b};
`endif
    endfunction

    state_t            state;
    state_t            state_next;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic              clear;
    logic              pix_ok;
    logic              last_col;
    logic              last_pix;
    logic              pos_ok;
    logic              vld_p1;
    logic              push;
    logic              pop;
    logic [4:0]        shift;
    logic              overflow;
    logic              done;
    logic signed [31:0] y_p1;
    logic signed [31:0] sh_p1;
    logic [7:0]        res_p1;
    logic [7:0]        head;
    logic              full;
    logic              empty;
    logic [CNT_W-1:0]  count;
    logic [31:0]       status;
    logic              unused_din;

    assign unused_din = ^din[31:5];

    assign clear    = en & we & (addr == ADDR_CLEAR);
    assign pix_ok   = pix_valid & ~clear;
    assign last_col = (col == COL_W'(IMG_WIDTH - 1));
    assign last_pix = last_col && (row == ROW_W'(IMG_HEIGHT - 1));
    assign pos_ok   = (row >= ROW_W'(2)) && (col >= COL_W'(2));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (pix_ok) begin
            if (last_col) begin
                col <= '0;
                row <= (row == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (clear)
            state_next = IDLE;
        else if (pix_ok)
            state_next = last_pix ? DONE : RUN;
    end

    // Stage p0 -> p1: the engine result for a masked-in pixel arrives one cycle later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            vld_p1 <= 1'b0;
        else if (clear)
            vld_p1 <= 1'b0;
        else
            vld_p1 <= pix_ok & pos_ok;
    end

    // Stage p1: combinational post-processing straight into the FIFO write port.
    assign y_p1   = conv_y;
    assign sh_p1  = y_p1 >>> shift;
    assign res_p1 = saturate(sh_p1);
    assign push   = vld_p1 & ~clear;
    assign pop    = en & ~we & (addr == ADDR_POP) & ~empty;

    conv_out_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clear),
        .push  (push),
        .din   (res_p1),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift    <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            if (en && we && addr == ADDR_SHIFT)
                shift <= din[4:0];
            if (clear) begin
                overflow <= 1'b0;
                done     <= 1'b0;
            end else begin
                if (push && full && !pop)
                    overflow <= 1'b1;
                if (state_next == DONE && state != DONE)
                    done <= 1'b1;
            end
        end
    end

    always_comb begin
        status                       = '0;
        status[ST_EMPTY]             = empty;
        status[ST_FULL]              = full;
        status[ST_OVERFLOW]          = overflow;
        status[ST_DONE]              = done;
        status[ST_COUNT_LSB +: 8]    = 8'(count);
    end

    // Registered read port: one cycle of valid data, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
        end else if (en && !we) begin
            case (addr)
                ADDR_POP:    dout <= empty ? 32'd0 : extend(head);
                ADDR_STATUS: dout <= status;
                default:     dout <= '0;
            endcase
        end else begin
            dout <= '0;
        end
    end

endmodule

// File: tb/tb_conv_out_stage.sv
// Directed-plus-random bench for conv_out_stage against a queue-based reference model.
module tb_conv_out_stage;
    import conv_pkg::*;

    localparam int W     = 8;
    localparam int H     = 8;
    localparam int NPIX  = W * H;
    localparam int DEPTH = 64;

`ifdef CONV_OUT_RELU_EN
    localparam logic [31:0] EXP_SAT_HI = 32'h0000_00FF;
    localparam logic [31:0] EXP_NEG    = 32'h0000_0000;
`else
    localparam logic [31:0] EXP_SAT_HI = 32'h0000_007F;
    localparam logic [31:0] EXP_NEG    = 32'hFFFF_FF80;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_valid;
    logic [31:0] conv_y;
    logic [3:0]  addr, addr_s;
    logic        en, we, en_s, we_s;
    logic [31:0] din, din_s;
    logic [31:0] dout, dout_s;

    always #5 clk = ~clk;

    conv_out_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .conv_y(conv_y),
        .addr(addr), .en(en), .we(we), .din(din), .dout(dout)
    );

    conv_out_stage #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .FIFO_DEPTH(4)) dut_small (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .conv_y(conv_y),
        .addr(addr_s), .en(en_s), .we(we_s), .din(din_s), .dout(dout_s)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] mq[$];
    int          m_pos;
    bit          m_done, m_ovf;
    int          m_shift;
    int          yv[NPIX];

    function automatic logic [31:0] model_val(input int y, input int sh);
        longint v;
        v = longint'(y) >>> sh;
`ifdef CONV_OUT_RELU_EN
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
`else
        if (v < -128) v = -128;
        if (v > 127)  v = 127;
`endif
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_status();
        int n;
        int s;
        n = mq.size();
        s = (n << 8) | (m_done ? 8 : 0) | (m_ovf ? 4 : 0) | ((n == DEPTH) ? 2 : 0) | ((n == 0) ? 1 : 0);
        return 32'(s);
    endfunction

    function automatic void model_clear();
        mq.delete();
        m_pos  = 0;
        m_done = 1'b0;
        m_ovf  = 1'b0;
    endfunction

    function automatic void model_pixel(input int y);
        int r, c;
        r = m_pos / W;
        c = m_pos % W;
        if (r >= 2 && c >= 2) begin
            if (mq.size() == DEPTH) m_ovf = 1'b1;
            else mq.push_back(model_val(y, m_shift));
        end
        if (m_pos == NPIX - 1) m_done = 1'b1;
        m_pos = (m_pos + 1) % NPIX;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 1'b1; addr = a; din = d;
        @(negedge clk);
        en = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clk);
        en = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        en = 1'b0;
        d = dout;
    endtask

    task automatic pop_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        bus_read(ADDR_POP, d);
        e = (mq.size() > 0) ? mq.pop_front() : 32'd0;
        check(tag, d, e);
    endtask

    task automatic status_check(input string tag);
        logic [31:0] d;
        bus_read(ADDR_STATUS, d);
        check(tag, d, model_status());
    endtask

    // Back-to-back pixels; conv_y carries pixel i's result in the cycle after its pix_valid.
    task automatic stream(input int n, input int pop_s_at);
        for (int i = 0; i <= n; i++) begin
            @(negedge clk);
            pix_valid = (i < n);
            conv_y    = (i > 0) ? yv[i-1] : $urandom;
            en_s      = (i == pop_s_at);
            we_s      = 1'b0;
            addr_s    = ADDR_POP;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        en_s      = 1'b0;
        conv_y    = $urandom;
        for (int i = 0; i < n; i++) model_pixel(yv[i]);
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NPIX; i++) begin
            case ($urandom_range(0, 3))
                0: yv[i] = int'($urandom_range(0, 400)) - 200;
                1: yv[i] = int'($urandom);
                2: yv[i] = int'($urandom_range(0, 255));
                default: yv[i] = -int'($urandom_range(0, 100000));
            endcase
        end
    endtask

    task automatic single(input int sh, input int y, input logic [31:0] expc, input string tag);
        logic [31:0] d;
        bus_write(ADDR_CLEAR, 32'd0);
        model_clear();
        bus_write(ADDR_SHIFT, 32'(sh));
        m_shift = sh;
        for (int i = 0; i < NPIX; i++) yv[i] = 0;
        yv[18] = y;
        stream(19, -1);
        bus_read(ADDR_POP, d);
        if (mq.size() > 0) void'(mq.pop_front());
        check(tag, d, expc);
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] e_small;
        rst = 1'b1; pix_valid = 1'b0; conv_y = '0;
        en = 1'b0; we = 1'b0; addr = '0; din = '0;
        en_s = 1'b0; we_s = 1'b0; addr_s = '0; din_s = '0;
        model_clear();
        m_shift = 0;
        repeat (3) @(negedge clk);
        check("reset_dout", dout, 32'd0);
        rst = 1'b0;
        status_check("reset_status");

        // Frame count with constant data
        bus_write(ADDR_SHIFT, 32'd0);
        for (int i = 0; i < NPIX; i++) yv[i] = 10;
        stream(NPIX, -1);
        status_check("frame_status");
        while (mq.size() > 0) pop_check("frame_pop");
        status_check("frame_drained");

        // Read protocol
        bus_read(ADDR_POP, d);
        check("empty_pop", d, 32'd0);
        status_check("empty_pop_count");
        @(negedge clk);
        check("status_release", dout, 32'd0);

        // Border masking
        bus_write(ADDR_CLEAR, 32'd0);
        model_clear();
        for (int i = 0; i < NPIX; i++) yv[i] = i;
        stream(NPIX, -1);
        status_check("border_status");
        while (mq.size() > 0) pop_check("border_pop");

        // Random frames with random shift
        for (int f = 0; f < 3; f++) begin
            m_shift = $urandom_range(0, 31);
            bus_write(ADDR_SHIFT, 32'(m_shift) | ($urandom & 32'hFFFF_FFE0));
            fill_rand();
            stream(NPIX, -1);
            status_check("rand_status");
            while (mq.size() > 0) pop_check("rand_pop");
        end

        // Arithmetic corner cases
        single(4, 32'h0000_1234, EXP_SAT_HI, "arith_sat_hi");
        single(1, -300, EXP_NEG, "arith_neg");
        single(0, 32'h50, 32'h50, "arith_pass");

        // Overflow on the depth-4 instance
        bus_write(ADDR_CLEAR, 32'd0);
        model_clear();
        @(negedge clk); en_s = 1'b1; we_s = 1'b1; addr_s = ADDR_CLEAR;
        @(negedge clk); en_s = 1'b0; we_s = 1'b0;
        m_shift = 0;
        bus_write(ADDR_SHIFT, 32'd0);
        fill_rand();
        e_small = model_val(yv[18], 0);
        stream(NPIX, -1);
        @(negedge clk); en_s = 1'b1; we_s = 1'b0; addr_s = ADDR_STATUS;
        @(negedge clk); en_s = 1'b0;
        check("ovf_status", dout_s, 32'h0000_040E);
        stream(19, 19);
        check("ovf_pop_data", dout_s, e_small);
        @(negedge clk); en_s = 1'b1; we_s = 1'b0; addr_s = ADDR_STATUS;
        @(negedge clk); en_s = 1'b0;
        check("ovf_pop_push", dout_s, 32'h0000_040E);
        status_check("big_no_ovf");

        // Clear one cycle after a masked-in pixel
        bus_write(ADDR_CLEAR, 32'd0);
        model_clear();
        bus_write(ADDR_SHIFT, 32'd4);
        m_shift = 4;
        fill_rand();
        stream(18, -1);
        @(negedge clk); pix_valid = 1'b1; conv_y = $urandom;
        @(negedge clk); pix_valid = 1'b0; conv_y = 32'h7FFF_0000;
        en = 1'b1; we = 1'b1; addr = ADDR_CLEAR;
        @(negedge clk); en = 1'b0; we = 1'b0;
        model_clear();
        status_check("clear_status");
        for (int i = 0; i < NPIX; i++) yv[i] = 0;
        yv[18] = 32'h100;
        stream(19, -1);
        bus_read(ADDR_POP, d);
        if (mq.size() > 0) void'(mq.pop_front());
        check("shift_kept", d, 32'h10);

        // pix_valid together with clear is ignored
        @(negedge clk); pix_valid = 1'b1; en = 1'b1; we = 1'b1; addr = ADDR_CLEAR;
        @(negedge clk); pix_valid = 1'b0; en = 1'b0; we = 1'b0;
        model_clear();
        for (int i = 0; i < NPIX; i++) yv[i] = 32'h300;
        yv[18] = 32'h200;
        stream(19, -1);
        pop_check("clear_pix_same");
        status_check("clear_pix_same_status");

        // Asynchronous reset mid-frame
        fill_rand();
        stream(30, -1);
        @(negedge clk); en = 1'b1; we = 1'b0; addr = ADDR_STATUS; pix_valid = 1'b1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_dout", dout, 32'd0);
        @(negedge clk);
        rst = 1'b0; en = 1'b0; pix_valid = 1'b0;
        model_clear();
        m_shift = 0;
        status_check("rst_status");
        for (int i = 0; i < NPIX; i++) yv[i] = 0;
        yv[18] = 32'h50;
        stream(19, -1);
        pop_check("rst_shift");
        status_check("final_status");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
